// File: rtl/pc_pkg.sv
// pc_pkg: op encodings shared by the decoder, the pc_stack sequencer and its bench
package pc_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_NEXT  = 3'd0,
        OP_SKIP  = 3'd1,
        OP_JUMP  = 3'd2,
        OP_JPAGE = 3'd3,
        OP_CALL  = 3'd4,
        OP_RET   = 3'd5
    } op_e;
endpackage

// File: rtl/call_stack.sv
// call_stack: circular return-address LIFO; a push while full overwrites the oldest entry
module call_stack #(
    parameter int W     = 12,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               rdata,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_evt,
    output logic                       unf_evt
);
    localparam int PTR_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;
    // r_ptr is the next write slot; once full it also points at the oldest entry
    assign w_ptr_inc = r_ptr == PTR_W'(DEPTH - 1) ? '0 : r_ptr + 1'b1;
    assign w_ptr_dec = r_ptr == '0 ? PTR_W'(DEPTH - 1) : r_ptr - 1'b1;
    assign full      = r_cnt == CNT_W'(DEPTH);
    assign empty     = r_cnt == '0;
    assign depth     = r_cnt;
    assign rdata     = r_mem[w_ptr_dec];
    assign ovf_evt   = push && full;
    assign unf_evt   = pop && empty;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (push) begin
            r_mem[r_ptr] <= wdata;
            r_ptr        <= w_ptr_inc;
            r_cnt        <= full ? r_cnt : r_cnt + 1'b1;
        end else if (pop && !empty) begin
            r_ptr <= w_ptr_dec;
            r_cnt <= r_cnt - 1'b1;
        end
    end
endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with next-address mux, call/return stack and sticky error flags
module pc_stack
    import pc_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 3,
    parameter int PAGE_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [OP_W-1:0]            op,
    input  logic [ADDR_W-1:0]          target,
    input  logic                       clr_err,
    output logic [ADDR_W-1:0]          adr,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       stack_full,
    output logic                       stack_empty,
    output logic                       ovf,
    output logic                       unf
);
    logic [ADDR_W-1:0] r_adr;
    logic [ADDR_W-1:0] w_inc;
    logic [ADDR_W-1:0] w_next;
    logic [ADDR_W-1:0] w_rdata;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_evt;
    logic              w_unf_evt;
    logic              r_ovf;
    logic              r_unf;
    assign w_inc  = r_adr + 1'b1;
    assign w_push = en && op == OP_CALL;
    assign w_pop  = en && op == OP_RET;
    // the JPAGE page comes from inc so the last word of a page jumps into the next one
    always_comb
        w_next = op == OP_SKIP                   ? r_adr + ADDR_W'(2) :
                 op == OP_JUMP || op == OP_CALL  ? target :
                 op == OP_JPAGE                  ? {w_inc[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]} :
                 op == OP_RET && !stack_empty    ? w_rdata :
                                                   w_inc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_adr <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (en) r_adr <= w_next;
            r_ovf <= (r_ovf && !clr_err) || w_ovf_evt;
            r_unf <= (r_unf && !clr_err) || w_unf_evt;
        end
    end
    call_stack #(.W(ADDR_W), .DEPTH(DEPTH)) u_stack (
        .clk    (clk),
        .reset  (reset),
        .push   (w_push),
        .pop    (w_pop),
        .wdata  (w_inc),
        .rdata  (w_rdata),
        .depth  (depth),
        .full   (stack_full),
        .empty  (stack_empty),
        .ovf_evt(w_ovf_evt),
        .unf_evt(w_unf_evt)
    );
    assign adr = r_adr;
    assign ovf = r_ovf;
    assign unf = r_unf;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed vector table, async-reset sequence and randomized queue-model check
module tb_pc_stack;
    import pc_pkg::*;
    localparam int DEPTH = 3;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [11:0] target = '0;
    logic        clr_err = 1'b0;
    logic [11:0] adr;
    logic [1:0]  depth;
    logic        stack_full, stack_empty, ovf, unf;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        logic        en;
        logic [2:0]  op;
        logic [11:0] tgt;
        logic        clr;
        logic [11:0] adr;
        logic [1:0]  dep;
        logic        ovf;
        logic        unf;
    } vec_t;
    vec_t vecs[$];

    logic [11:0] m_adr;
    logic [11:0] m_stk[$];
    logic        m_ovf, m_unf;

    pc_stack #(.ADDR_W(12), .DEPTH(DEPTH), .PAGE_W(8)) dut (
        .clk(clk), .reset(reset), .en(en), .op(op), .target(target), .clr_err(clr_err),
        .adr(adr), .depth(depth), .stack_full(stack_full), .stack_empty(stack_empty),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [11:0] a, input logic [1:0] d,
                             input logic o, input logic u);
        check({tag, " adr"}, 32'(adr), 32'(a));
        check({tag, " depth"}, 32'(depth), 32'(d));
        check({tag, " full"}, 32'(stack_full), 32'(d == 2'(DEPTH)));
        check({tag, " empty"}, 32'(stack_empty), 32'(d == 2'd0));
        check({tag, " ovf"}, 32'(ovf), 32'(o));
        check({tag, " unf"}, 32'(unf), 32'(u));
    endtask

    task automatic step(input logic e, input logic [2:0] o, input logic [11:0] t, input logic c);
        en = e; op = o; target = t; clr_err = c;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic e, input logic [2:0] o, input logic [11:0] t, input logic c,
                       input logic [11:0] a, input logic [1:0] d, input logic ov, input logic un);
        vec_t v;
        v.en = e; v.op = o; v.tgt = t; v.clr = c; v.adr = a; v.dep = d; v.ovf = ov; v.unf = un;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        en = 1'b0; op = OP_NEXT; target = '0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // reference: a bounded queue whose front is the oldest return address
    task automatic model(input logic e, input logic [2:0] o, input logic [11:0] t, input logic c);
        logic [11:0] inc;
        if (c) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (e) begin
            inc = m_adr + 12'd1;
            case (o)
                OP_SKIP:  m_adr = m_adr + 12'd2;
                OP_JUMP:  m_adr = t;
                OP_JPAGE: m_adr = (inc & 12'hF00) | (t & 12'h0FF);
                OP_CALL: begin
                    if (m_stk.size() == DEPTH) begin
                        void'(m_stk.pop_front());
                        m_ovf = 1'b1;
                    end
                    m_stk.push_back(inc);
                    m_adr = t;
                end
                OP_RET: begin
                    if (m_stk.size() == 0) begin
                        m_unf = 1'b1;
                        m_adr = inc;
                    end else m_adr = m_stk.pop_back();
                end
                default:  m_adr = inc;
            endcase
        end
    endtask

    initial begin
        add(1, OP_NEXT,  12'h000, 0, 12'h001, 0, 0, 0);
        add(1, OP_NEXT,  12'h000, 0, 12'h002, 0, 0, 0);
        add(1, OP_NEXT,  12'h000, 0, 12'h003, 0, 0, 0);
        add(1, OP_JUMP,  12'h123, 0, 12'h123, 0, 0, 0);
        add(1, OP_JUMP,  12'h456, 0, 12'h456, 0, 0, 0);
        add(1, OP_SKIP,  12'h000, 0, 12'h458, 0, 0, 0);
        add(1, OP_JUMP,  12'h1FF, 0, 12'h1FF, 0, 0, 0);
        add(1, OP_JPAGE, 12'h034, 0, 12'h234, 0, 0, 0);
        add(1, OP_JUMP,  12'hFFF, 0, 12'hFFF, 0, 0, 0);
        add(1, OP_NEXT,  12'h000, 0, 12'h000, 0, 0, 0);
        add(1, OP_JUMP,  12'hFFF, 0, 12'hFFF, 0, 0, 0);
        add(1, OP_SKIP,  12'h000, 0, 12'h001, 0, 0, 0);
        add(1, OP_JUMP,  12'h010, 0, 12'h010, 0, 0, 0);
        add(1, OP_CALL,  12'h100, 0, 12'h100, 1, 0, 0);
        add(1, OP_CALL,  12'h200, 0, 12'h200, 2, 0, 0);
        add(1, OP_CALL,  12'h300, 0, 12'h300, 3, 0, 0);
        add(1, OP_RET,   12'h000, 0, 12'h201, 2, 0, 0);
        add(1, OP_RET,   12'h000, 0, 12'h101, 1, 0, 0);
        add(1, OP_RET,   12'h000, 0, 12'h011, 0, 0, 0);
        add(1, OP_JUMP,  12'h010, 0, 12'h010, 0, 0, 0);
        add(1, OP_CALL,  12'h100, 0, 12'h100, 1, 0, 0);
        add(1, OP_CALL,  12'h200, 0, 12'h200, 2, 0, 0);
        add(1, OP_CALL,  12'h300, 0, 12'h300, 3, 0, 0);
        add(1, OP_CALL,  12'h400, 0, 12'h400, 3, 1, 0);
        add(1, OP_RET,   12'h000, 0, 12'h301, 2, 1, 0);
        add(1, OP_RET,   12'h000, 0, 12'h201, 1, 1, 0);
        add(1, OP_RET,   12'h000, 0, 12'h101, 0, 1, 0);
        add(1, OP_RET,   12'h000, 0, 12'h102, 0, 1, 1);
        add(1, OP_CALL,  12'h050, 0, 12'h050, 1, 1, 1);
        for (int i = 0; i < 5; i++) add(0, OP_CALL, 12'h777, 0, 12'h050, 1, 1, 1);
        add(0, OP_RET,   12'h000, 1, 12'h050, 1, 0, 0);
        add(1, OP_CALL,  12'h060, 0, 12'h060, 2, 0, 0);
        add(1, OP_CALL,  12'h070, 0, 12'h070, 3, 0, 0);
        add(1, OP_CALL,  12'h080, 1, 12'h080, 3, 1, 0);
        add(1, 3'd6,     12'h5A5, 0, 12'h081, 3, 1, 0);
        add(1, 3'd7,     12'h5A5, 0, 12'h082, 3, 1, 0);
        add(1, OP_NEXT,  12'h000, 1, 12'h083, 3, 0, 0);

        do_reset();
        #1;
        check_all("reset", 12'h000, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].en, vecs[i].op, vecs[i].tgt, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].adr, vecs[i].dep, vecs[i].ovf, vecs[i].unf);
        end

        // asynchronous reset between edges while two calls are outstanding
        do_reset();
        step(1, OP_CALL, 12'h100, 0);
        step(1, OP_CALL, 12'h200, 0);
        check_all("pre_async", 12'h200, 2, 0, 0);
        #2 reset = 1'b1;
        #1 check_all("async_rst", 12'h000, 0, 0, 0);
        #1 reset = 1'b0;
        step(1, OP_RET, 12'h000, 0);
        check_all("ret_after_rst", 12'h001, 0, 0, 1);
        step(1, OP_CALL, 12'h3F0, 0);
        check_all("call_after_rst", 12'h3F0, 1, 0, 1);
        step(1, OP_RET, 12'h000, 0);
        check_all("b2b_ret", 12'h002, 0, 0, 1);

        do_reset();
        m_adr = '0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            logic       e, c;
            logic [2:0] o;
            logic [11:0] t;
            e = $urandom_range(0, 7) != 0;
            o = 3'($urandom_range(0, 7));
            t = 12'($urandom);
            c = $urandom_range(0, 15) == 0;
            if ($urandom_range(0, 3) == 0) o = $urandom_range(0, 1) != 0 ? OP_CALL : OP_RET;
            step(e, o, t, c);
            model(e, o, t, c);
            check_all($sformatf("rnd%0d", i), m_adr, 2'(m_stk.size()), m_ovf, m_unf);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with a hardware call/return stack, the next-generation sequencer for TB4004-class cores. Each enabled clock cycle it computes the next instruction address as increment, skip, absolute jump, page-relative jump, call or return. It keeps return addresses in an internal circular LIFO of configurable depth. It sits between the instruction decoder, which supplies the operation and target, and the program memory address port.

## Interface
- ADDR_W, 12: address width in bits; legal range 4..16.
- DEPTH, 3: number of return-address stack entries; legal range 1..8.
- PAGE_W, 8: width of the in-page offset used by page-relative jumps; must be less than ADDR_W.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  advance enable; when 0, all state holds (stall).
- op  in  3  operation select; encodings are listed under Operation.
- target  in  ADDR_W  jump or call destination; page-relative jumps use only bits [PAGE_W-1:0].
- clr_err  in  1  synchronous clear of the sticky error flags.
- adr  out  ADDR_W  current program address; registered.
- depth  out  clog2(DEPTH+1)  number of valid stack entries; registered.
- stack_full  out  1  asserted when depth == DEPTH.
- stack_empty  out  1  asserted when depth == 0.
- ovf  out  1  sticky flag: a CALL was executed while the stack was full.
- unf  out  1  sticky flag: a RET was executed while the stack was empty.

## Operation
- Let inc = adr + 1, modulo 2^ADDR_W. All address arithmetic wraps silently; 0xFFF + 1 = 0x000 at the default width.
- Operations, applied only when en = 1:
  - 0 NEXT: adr <= inc.
  - 1 SKIP: adr <= adr + 2, modulo 2^ADDR_W.
  - 2 JUMP: adr <= target.
  - 3 JPAGE: adr <= {inc[ADDR_W-1:PAGE_W], target[PAGE_W-1:0]}. The page is taken from inc, not adr, so a JPAGE at the last word of a page lands in the following page.
  - 4 CALL: push inc onto the stack; adr <= target.
  - 5 RET: adr <= top of stack; pop.
  - 6 and 7: reserved; behave exactly as NEXT.
- Stack is a circular buffer with a top pointer.
  - CALL while not full: write the entry, advance the pointer, depth += 1.
  - CALL while full: overwrite the oldest entry (pointer wraps), depth stays at DEPTH, set ovf.
  - RET while empty: adr <= inc, depth stays 0, set unf; the pointer does not move.
- clr_err clears ovf and unf regardless of en. If an error event occurs in the same cycle as clr_err, the flag ends the cycle set (set wins).
- With en = 0, op and target are ignored: no state changes and no flag changes; only clr_err acts.

## Timing
- Reset (asynchronous, immediate) forces adr = 0, depth = 0, pointer = 0, all stack entries = 0, ovf = 0, unf = 0.
- Reset takes effect mid-operation, and the first rising edge after deassertion executes normally.
- All outputs are registered. The effect of op sampled at edge N is visible on adr, depth and the flags after edge N; latency is 1 cycle.
- stack_full and stack_empty are decoded from the registered depth and carry no extra latency.
- Exactly one operation executes per enabled cycle, so no push/pop collision is possible.
- Back-to-back CALL then RET returns to the address following the CALL on the very next cycle.

## Structure
- Shared package `pc_pkg`: the op encodings OP_NEXT, OP_SKIP, OP_JUMP, OP_JPAGE, OP_CALL, OP_RET, plus the op width constant, so the decoder and the bench use the same values.
- One sub-module `call_stack`: a parametrised circular LIFO.
  - Parameters: width and depth.
  - Inputs: push, pop and wdata.
  - Outputs: rdata (top of stack), depth, full, empty, ovf_evt and unf_evt.
  - pc_stack contains only the next-address multiplexer and the flag registers.

## Test plan
All scenarios use ADDR_W=12, DEPTH=3, PAGE_W=8.
- Reset and increment: release reset, then 3 cycles of NEXT -> adr = 0x000, 0x001, 0x002, 0x003; at 0xFFF, NEXT -> 0x000.
- Jumps and skip: at adr 0x123, JUMP target 0x456 -> 0x456; then SKIP -> 0x458; at 0x1FF, JPAGE target 0x034 -> 0x234.
- Nested calls:
  - CALL 0x100 at 0x010, then CALL 0x200, then CALL 0x300 -> depth = 3, stack_full = 1.
  - Three RETs -> adr = 0x201, then 0x101, then 0x011; stack_empty = 1 and ovf = 0 throughout.
- Overflow wrap:
  - Four CALLs from 0x010 (to 0x100, 0x200, 0x300, 0x400) -> ovf = 1, depth = 3.
  - RETs then yield 0x301, 0x201, 0x101; a fourth RET -> unf = 1, adr = 0x102.
- Stall and clear:
  - en = 0 for 5 cycles with op = CALL -> adr and depth unchanged.
  - clr_err pulsed while ovf = 1 -> ovf = 0 on the next cycle.
- Asynchronous reset mid-call:
  - With depth = 2, assert reset between clock edges -> adr = 0 and depth = 0 immediately.
  - The next RET -> unf = 1, adr = 0x001.
